// File: rtl/ex_pkg.sv
// ex_pkg: shared types and encodings for the execute-stage divide/sqrt scheduler
package ex_pkg;
  localparam int EX_XLEN = 64;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic UNIT_SEL_INT = 1'b0;
  localparam logic UNIT_SEL_FP = 1'b1;
  localparam logic [3:0] F_DIV = 4'h0;
  localparam logic [3:0] F_DIVU = 4'h1;
  localparam logic [3:0] F_REM = 4'h2;
  localparam logic [3:0] F_REMU = 4'h3;
  localparam logic [3:0] F_FDIV = 4'h8;
  localparam logic [3:0] F_FSQRT = 4'h9;
  typedef struct packed {
    logic [EX_XLEN-1:0] result;
    logic [4:0] rd;
    logic reg_type;
  } res_t;
endpackage

// File: rtl/ex_mc_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the side not granted last wins a tie
module rr_arb2 (
  input logic clk,
  input logic reset,
  input logic [1:0] req,
  input logic en,
  output logic [1:0] gnt,
  output logic sel
);
  logic last_grant;
  assign sel = req[1] & (~req[0] | ~last_grant);
  assign gnt = en ? {req[1] & sel, req[0] & ~sel} : 2'b00;
  always_ff @(posedge clk or posedge reset)
    if (reset) last_grant <= 1'b1;
    else if (|gnt) last_grant <= sel;
endmodule

// File: rtl/ex_mc_arbiter.sv
// ex_mc_arbiter: schedules integer and FP requests onto the shared divide/sqrt unit
module ex_mc_arbiter
  import ex_pkg::*;
#(
  parameter int XLEN = EX_XLEN,
  parameter int TIMEOUT = 128
) (
  input logic clk,
  input logic reset,
  input logic flush,
  input logic int_valid,
  output logic int_ready,
  input logic [XLEN-1:0] int_op1,
  input logic [XLEN-1:0] int_op2,
  input logic [4:0] int_rd,
  input logic [3:0] int_funct,
  input logic fp_valid,
  output logic fp_ready,
  input logic [XLEN-1:0] fp_op1,
  input logic [XLEN-1:0] fp_op2,
  input logic [4:0] fp_rd,
  input logic [3:0] fp_funct,
  output logic unit_start,
  output logic unit_sel,
  output logic [XLEN-1:0] unit_op1,
  output logic [XLEN-1:0] unit_op2,
  output logic [3:0] unit_funct,
  output logic unit_abort,
  input logic unit_done,
  input logic [XLEN-1:0] unit_result,
  output logic wb_valid,
  input logic wb_ready,
  output logic [XLEN-1:0] wb_result,
  output logic [4:0] wb_rd,
  output logic wb_reg_type,
  output logic busy,
  output logic err_timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] gnt;
  logic gsel, hs, expired;
  res_t rec;
  rr_arb2 u_arb (
    .clk,
    .reset,
    .req({fp_valid, int_valid}),
    .en(state == IDLE && !flush),
    .gnt,
    .sel(gsel)
  );
  assign int_ready = gnt[0];
  assign fp_ready = gnt[1];
  assign hs = |gnt;
  assign expired = state == BUSY && !unit_done && cnt == CW'(TIMEOUT - 1);
  assign wb_result = rec.result;
  assign wb_rd = rec.rd;
  assign wb_reg_type = rec.reg_type;
  // flush outranks completion and watchdog in every state
  always_comb begin
    state_n = state;
    wb_valid = state == RESP;
    busy = state != IDLE;
    state_n = state == IDLE ? (hs ? BUSY : IDLE)
            : state == BUSY ? (flush || expired ? IDLE : unit_done ? RESP : BUSY)
            : (flush || wb_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      unit_start <= 1'b0;
      unit_abort <= 1'b0;
      err_timeout <= 1'b0;
      unit_sel <= UNIT_SEL_INT;
      unit_op1 <= '0;
      unit_op2 <= '0;
      unit_funct <= '0;
      rec <= '0;
    end else begin
      unit_start <= hs;
      unit_abort <= state == BUSY && (flush || expired);
      err_timeout <= expired && !flush;
      cnt <= hs ? '0 : cnt + CW'(state == BUSY);
      if (hs) begin
        unit_sel <= gsel;
        unit_op1 <= gsel ? fp_op1 : int_op1;
        unit_op2 <= gsel ? fp_op2 : int_op2;
        unit_funct <= gsel ? fp_funct : int_funct;
        rec.rd <= gsel ? fp_rd : int_rd;
        rec.reg_type <= gsel;
      end
      if (state == BUSY && unit_done && !flush) rec.result <= unit_result;
    end
endmodule
